// File: rtl/dpdm_txn_sched.sv
// dpdm_txn_sched: sequences token/data/handshake transmit, bus turnaround and timed reply wait for one host transaction.
module dpdm_txn_sched #(
    parameter int unsigned TOK_CYC  = 35,
    parameter int unsigned DATA_CYC = 95,
    parameter int unsigned HS_CYC   = 15,
    parameter int unsigned TURN_CYC = 2,
    parameter int unsigned TIMEOUT  = 200
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       req_i,
    input  logic [1:0] kind_i,
    output logic       req_ack_o,
    output logic       busy_o,
    output logic [1:0] tx_type_o,
    output logic       tx_start_o,
    output logic       re_o,
    input  logic       rx_active_i,
    input  logic       rx_done_i,
    output logic       txn_done_o,
    output logic       timeout_o,
    output logic       err_o
);
    typedef enum logic [2:0] {IDLE, TX_TOK, TX_DATA, TX_HS, TURN, RX_WAIT, RX_PKT} state_t;
    localparam logic [7:0] TOK_LAST  = 8'(TOK_CYC - 1);
    localparam logic [7:0] DATA_LAST = 8'(DATA_CYC - 1);
    localparam logic [7:0] HS_LAST   = 8'(HS_CYC - 1);
    localparam logic [7:0] TURN_LAST = 8'(TURN_CYC - 1);
    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
    state_t     state_q, state_d;
    logic [7:0] cnt_q;
    logic [1:0] kind_q;
    logic       done_q, done_d, tmo_q, tmo_d;
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE:    if (req_ack_o) state_d = (kind_i == 2'b10) ? TX_HS : TX_TOK;
            TX_TOK:  if (cnt_q == TOK_LAST) state_d = (kind_q == 2'b00) ? TX_DATA : TURN;
            TX_DATA: if (cnt_q == DATA_LAST) state_d = TURN;
            TX_HS:   if (cnt_q == HS_LAST) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            TURN:    if (cnt_q == TURN_LAST) state_d = RX_WAIT;
            RX_WAIT: if (rx_done_i) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else if (rx_active_i) begin
                state_d = RX_PKT;
            end else if (cnt_q == TO_LAST) begin
                state_d = IDLE;
                tmo_d   = 1'b1;
            end
            RX_PKT:  if (rx_done_i) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else if (cnt_q == TO_LAST) begin
                state_d = IDLE;
                tmo_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            kind_q  <= 2'b00;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
            kind_q  <= req_ack_o ? kind_i : kind_q;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
        end
    end
    assign req_ack_o  = (state_q == IDLE) && req_i && (kind_i != 2'b11);
    assign err_o      = (state_q == IDLE) && req_i && (kind_i == 2'b11);
    assign busy_o     = state_q != IDLE;
    assign tx_type_o  = (state_q == TX_TOK)  ? 2'b01 :
                        (state_q == TX_DATA) ? 2'b10 :
                        (state_q == TX_HS)   ? 2'b11 : 2'b00;
    assign tx_start_o = (state_q inside {TX_TOK, TX_DATA, TX_HS}) && (cnt_q == 8'd0);
    assign re_o       = (state_q == RX_WAIT) || (state_q == RX_PKT);
    assign txn_done_o = done_q;
    assign timeout_o  = tmo_q;
endmodule

// File: tb/tb_dpdm_txn_sched.sv
// tb_dpdm_txn_sched: directed vector table plus hand sequences for busy, kind latching and mid-transaction reset.
module tb_dpdm_txn_sched;
    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       req = 1'b0;
    logic [1:0] kind = 2'b00;
    logic       rx_active = 1'b0;
    logic       rx_done = 1'b0;
    logic       req_ack_o, busy_o, tx_start_o, re_o, txn_done_o, timeout_o, err_o;
    logic [1:0] tx_type_o;
    int         checks = 0;
    int         failures = 0;

    dpdm_txn_sched dut (
        .clk(clk), .rst_b(rst_b), .req_i(req), .kind_i(kind),
        .req_ack_o(req_ack_o), .busy_o(busy_o), .tx_type_o(tx_type_o),
        .tx_start_o(tx_start_o), .re_o(re_o), .rx_active_i(rx_active),
        .rx_done_i(rx_done), .txn_done_o(txn_done_o), .timeout_o(timeout_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] kind;
        int act, done, tok, dat, hs, st_n, st2, re_f, re_l, end_c;
        logic [1:0] end_k;
    } vec_t;

    vec_t tv [7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in an IDLE cycle; returns in the cycle the closing pulse is seen.
    task automatic run_txn(input vec_t v, input string tag);
        int tok = 0, dat = 0, hs = 0, st_n = 0, st2 = 0, re_f = 0, re_l = 0, end_c = 0;
        logic [1:0] end_k = 2'b00;
        req = 1'b1;
        kind = v.kind;
        #1;
        chk({tag, ".ack"}, int'(req_ack_o), 1);
        tick();
        req = 1'b0;
        for (int c = 1; c <= 600 && end_c == 0; c++) begin
            if (tx_type_o == 2'b01) tok++;
            if (tx_type_o == 2'b10) dat++;
            if (tx_type_o == 2'b11) hs++;
            if (tx_start_o) begin
                st_n++;
                if (st_n == 2) st2 = c;
            end
            if (c == 1) chk({tag, ".start1"}, int'(tx_start_o), 1);
            if (re_o) begin
                if (re_f == 0) re_f = c;
                re_l = c;
            end
            if (txn_done_o || timeout_o) begin
                end_c = c;
                end_k = {txn_done_o, timeout_o};
            end else begin
                rx_active = (c == v.act);
                rx_done = (c == v.done);
                tick();
            end
        end
        rx_active = 1'b0;
        rx_done = 1'b0;
        chk({tag, ".tok_cycles"}, tok, v.tok);
        chk({tag, ".data_cycles"}, dat, v.dat);
        chk({tag, ".hs_cycles"}, hs, v.hs);
        chk({tag, ".start_count"}, st_n, v.st_n);
        chk({tag, ".start2_cycle"}, st2, v.st2);
        chk({tag, ".re_first"}, re_f, v.re_f);
        chk({tag, ".re_last"}, re_l, v.re_l);
        chk({tag, ".end_cycle"}, end_c, v.end_c);
        chk({tag, ".end_kind"}, int'(end_k), int'(v.end_k));
        chk({tag, ".busy_at_end"}, int'(busy_o), 0);
    endtask

    initial begin
        vec_t rv;
        int bad_ack = 0;
        tv[0] = '{2'd0, 140, 152, 35, 95, 0, 2, 36, 133, 152, 153, 2'b10};
        tv[1] = '{2'd1, 0, 0, 35, 0, 0, 1, 0, 38, 237, 238, 2'b01};
        tv[2] = '{2'd2, 0, 0, 0, 0, 15, 1, 0, 0, 0, 16, 2'b10};
        tv[3] = '{2'd1, 237, 0, 35, 0, 0, 1, 0, 38, 437, 438, 2'b01};
        tv[4] = '{2'd1, 237, 437, 35, 0, 0, 1, 0, 38, 437, 438, 2'b10};
        tv[5] = '{2'd1, 50, 50, 35, 0, 0, 1, 0, 38, 50, 51, 2'b10};
        tv[6] = '{2'd1, 0, 38, 35, 0, 0, 1, 0, 38, 38, 39, 2'b10};
        rv    = '{2'd1, 0, 40, 35, 0, 0, 1, 0, 38, 40, 41, 2'b10};

        #2;
        chk("rst.tx_type", int'(tx_type_o), 0);
        chk("rst.re", int'(re_o), 0);
        chk("rst.busy", int'(busy_o), 0);
        chk("rst.tx_start", int'(tx_start_o), 0);
        chk("rst.txn_done", int'(txn_done_o), 0);
        chk("rst.timeout", int'(timeout_o), 0);
        rst_b = 1'b1;
        tick();

        req = 1'b1;
        kind = 2'b11;
        #1;
        chk("illegal.err", int'(err_o), 1);
        chk("illegal.ack", int'(req_ack_o), 0);
        tick();
        chk("illegal.busy", int'(busy_o), 0);
        req = 1'b0;
        #1;
        chk("illegal.err_drop", int'(err_o), 0);
        tick();

        for (int i = 0; i < 7; i++) run_txn(tv[i], $sformatf("vec%0d", i));
        tick();
        chk("pulse_width.txn_done", int'(txn_done_o), 0);
        chk("pulse_width.timeout", int'(timeout_o), 0);

        req = 1'b1;
        kind = 2'b00;
        #1;
        chk("busy.ack", int'(req_ack_o), 1);
        tick();
        req = 1'b0;
        for (int c = 1; c <= 134; c++) begin
            if (c == 10) kind = 2'b01;
            if (c == 60) begin
                req = 1'b1;
                kind = 2'b10;
                #1;
            end
            if (busy_o && req_ack_o) bad_ack++;
            if (c == 100) chk("busy.kind_latched", int'(tx_type_o), 2);
            if (c == 134) begin
                chk("busy.txn_done", int'(txn_done_o), 1);
                chk("busy.b2b_ack", int'(req_ack_o), 1);
            end else begin
                rx_done = (c == 133);
                tick();
            end
        end
        rx_done = 1'b0;
        chk("busy.ack_while_busy", bad_ack, 0);
        tick();
        req = 1'b0;
        chk("b2b.hs_type", int'(tx_type_o), 3);
        chk("b2b.hs_start", int'(tx_start_o), 1);
        repeat (15) tick();
        chk("b2b.hs_done", int'(txn_done_o), 1);
        tick();
        chk("b2b.hs_done_drop", int'(txn_done_o), 0);

        req = 1'b1;
        kind = 2'b00;
        #1;
        tick();
        req = 1'b0;
        repeat (59) tick();
        chk("midrst.pre_type", int'(tx_type_o), 2);
        rst_b = 1'b0;
        #1;
        chk("midrst.tx_type", int'(tx_type_o), 0);
        chk("midrst.re", int'(re_o), 0);
        chk("midrst.busy", int'(busy_o), 0);
        chk("midrst.tx_start", int'(tx_start_o), 0);
        tick();
        rst_b = 1'b1;
        tick();
        run_txn(rv, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
